voice_alloc: RTL and testbench

VOICE_ALLOC -- requirements
Module: voice_alloc

---
 rtl/synth_pkg.sv | 10 +
 rtl/voice_alloc_if.sv | 10 +
 rtl/voice_pick.sv | 34 +++
 rtl/voice_alloc.sv | 92 +++++++++
 tb/tb_voice_alloc.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: shared note codes, voice count, allocator FSM encoding and rank type
package synth_pkg;
   localparam int NUM_VOICES = 4;
   typedef logic [3:0] note_t;
   typedef logic [1:0] rank_t;
   typedef logic [1:0] vidx_t;
   localparam note_t SILENT = 4'd0;
   localparam note_t NOTE_MAX = 4'd15;
   typedef enum logic {ST_IDLE, ST_UPDATE} va_state_t;
endpackage

// File: rtl/voice_alloc_if.sv
// voice_alloc_if: note request valid/ready handshake
interface voice_alloc_if;
   import synth_pkg::*;
   logic note_valid;
   logic note_ready;
   logic note_on;
   note_t note_code;
   modport master(output note_valid, note_on, note_code, input note_ready);
   modport slave(input note_valid, note_on, note_code, output note_ready);
endinterface

// File: rtl/voice_pick.sv
// voice_pick: finds matching, lowest free and oldest voices for a request
module voice_pick
   import synth_pkg::*;
(
   input  logic [NUM_VOICES-1:0]        busy_i,
   input  note_t [NUM_VOICES-1:0]       code_i,
   input  rank_t [NUM_VOICES-1:0]       rank_i,
   input  note_t                        req_code_i,
   output vidx_t                        match_idx_o,
   output logic                         match_o,
   output vidx_t                        free_idx_o,
   output logic                         free_o,
   output vidx_t                        oldest_idx_o
);
   always_comb begin
      match_idx_o = '0;
      match_o = 1'b0;
      free_idx_o = '0;
      free_o = 1'b0;
      oldest_idx_o = '0;
      // descending scan so the lowest index wins
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (busy_i[i] && code_i[i] == req_code_i) begin
            match_o = 1'b1;
            match_idx_o = vidx_t'(i);
         end
         if (!busy_i[i]) begin
            free_o = 1'b1;
            free_idx_o = vidx_t'(i);
         end
         if (busy_i[i] && rank_i[i] == 2'd3) oldest_idx_o = vidx_t'(i);
      end
   end
endmodule

// File: rtl/voice_alloc.sv
// voice_alloc: 4-voice note allocator with age-ranked stealing and retrigger
module voice_alloc
   import synth_pkg::*;
#(
   parameter bit RETRIGGER = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   voice_alloc_if.slave          note_if,
   input  logic                  all_off_i,
   output note_t                 tone0_o,
   output note_t                 tone1_o,
   output note_t                 tone2_o,
   output note_t                 tone3_o,
   output logic [NUM_VOICES-1:0] voice_busy_o,
   output logic                  stolen_o
);
   va_state_t state_q;
   logic ready_q, stolen_q, stolen_d, req_on_q, match, free, act_on, act_off;
   note_t req_code_q;
   note_t [NUM_VOICES-1:0] tone_q, tone_d;
   rank_t [NUM_VOICES-1:0] rank_q, rank_d;
   logic [NUM_VOICES-1:0] busy;
   vidx_t match_idx, free_idx, oldest_idx, tgt;
   logic [2:0] old_rank;
   always_comb begin
      busy = '0;
      for (int i = 0; i < NUM_VOICES; i++) busy[i] = tone_q[i] != SILENT;
   end
   voice_pick u_pick (
      .busy_i(busy), .code_i(tone_q), .rank_i(rank_q), .req_code_i(req_code_q),
      .match_idx_o(match_idx), .match_o(match), .free_idx_o(free_idx),
      .free_o(free), .oldest_idx_o(oldest_idx)
   );
   // a free voice counts as rank 4 so every busy voice ages when it is allocated
   always_comb begin
      tgt = (!req_on_q || match) ? match_idx : free ? free_idx : oldest_idx;
      old_rank = busy[tgt] ? {1'b0, rank_q[tgt]} : 3'd4;
      act_on = req_on_q && req_code_q != SILENT && (!match || RETRIGGER);
      act_off = !req_on_q && req_code_q != SILENT && match;
      stolen_d = act_on && !match && !free;
      tone_d = tone_q;
      rank_d = rank_q;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if ((act_on || act_off) && vidx_t'(i) == tgt) begin
            tone_d[i] = act_on ? req_code_q : SILENT;
            rank_d[i] = '0;
         end else if (act_on && busy[i] && {1'b0, rank_q[i]} < old_rank)
            rank_d[i] = rank_q[i] + 2'd1;
         else if (act_off && busy[i] && {1'b0, rank_q[i]} > old_rank)
            rank_d[i] = rank_q[i] - 2'd1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         stolen_q <= 1'b0;
         req_on_q <= 1'b0;
         req_code_q <= SILENT;
         tone_q <= '0;
         rank_q <= '0;
      end else if (all_off_i) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         stolen_q <= 1'b0;
         tone_q <= '0;
         rank_q <= '0;
      end else if (state_q == ST_UPDATE) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         stolen_q <= stolen_d;
         tone_q <= tone_d;
         rank_q <= rank_d;
      end else begin
         stolen_q <= 1'b0;
         ready_q <= !(note_if.note_valid && ready_q);
         if (note_if.note_valid && ready_q) begin
            state_q <= ST_UPDATE;
            req_on_q <= note_if.note_on;
            req_code_q <= note_if.note_code;
         end
      end
   end
   assign note_if.note_ready = ready_q;
   assign tone0_o = tone_q[0];
   assign tone1_o = tone_q[1];
   assign tone2_o = tone_q[2];
   assign tone3_o = tone_q[3];
   assign voice_busy_o = busy;
   assign stolen_o = stolen_q;
endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: directed vectors with hand-computed voice allocation results
module tb_voice_alloc;
   import synth_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic all_off = 1'b0;
   note_t t0, t1, t2, t3;
   logic [3:0] busy;
   logic stolen;
   int n_chk = 0;
   int n_err = 0;
   voice_alloc_if vif();
   voice_alloc #(.RETRIGGER(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .note_if(vif.slave), .all_off_i(all_off),
      .tone0_o(t0), .tone1_o(t1), .tone2_o(t2), .tone3_o(t3),
      .voice_busy_o(busy), .stolen_o(stolen)
   );
   always #5 clk = ~clk;
   function automatic logic [15:0] tones();
      return {t3, t2, t1, t0};
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic wait_ready();
      int n = 0;
      while (!vif.note_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!vif.note_ready) check("ready_timeout", 0, 1);
   endtask
   // called and returns at a negedge; outputs then reflect the request
   task automatic send(input logic on, input note_t code);
      wait_ready();
      vif.note_valid = 1'b1;
      vif.note_on = on;
      vif.note_code = code;
      @(posedge clk);
      @(negedge clk);
      vif.note_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic panic();
      all_off = 1'b1;
      @(negedge clk);
      all_off = 1'b0;
   endtask
   initial begin
      vif.note_valid = 1'b0;
      vif.note_on = 1'b0;
      vif.note_code = SILENT;
      #12;
      check("rst_tones", tones(), 16'h0000);
      check("rst_busy", busy, 4'h0);
      check("rst_stolen", stolen, 0);
      check("rst_ready", vif.note_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", vif.note_ready, 1);
      // fill all four voices
      send(1, 4'd3); check("fill3_stolen", stolen, 0);
      send(1, 4'd5); check("fill5_stolen", stolen, 0);
      send(1, 4'd7); check("fill7_stolen", stolen, 0);
      send(1, 4'd9); check("fill9_stolen", stolen, 0);
      check("fill_tones", tones(), 16'h9753);
      check("fill_busy", busy, 4'hf);
      send(1, 4'd12);
      check("steal_tones", tones(), 16'h975c);
      check("steal_pulse", stolen, 1);
      @(negedge clk);
      check("steal_pulse_end", stolen, 0);
      send(0, 4'd7);
      check("off7_tones", tones(), 16'h905c);
      check("off7_busy", busy, 4'b1011);
      send(1, 4'd4);
      check("on4_tones", tones(), 16'h945c);
      check("on4_stolen", stolen, 0);
      send(0, 4'd14);
      check("off14_tones", tones(), 16'h945c);
      send(1, 4'd0);
      check("on0_tones", tones(), 16'h945c);
      check("on0_busy", busy, 4'hf);
      panic();
      check("panic_tones", tones(), 16'h0000);
      check("panic_ready", vif.note_ready, 1);
      // valid held high: ready alternates and accepts land every 2 cycles
      vif.note_valid = 1'b1;
      vif.note_on = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         check("b2b_ready_hi", vif.note_ready, 1);
         vif.note_code = note_t'(k);
         @(negedge clk);
         check("b2b_ready_lo", vif.note_ready, 0);
         @(negedge clk);
      end
      vif.note_valid = 1'b0;
      check("b2b_tones", tones(), 16'h0321);
      panic();
      send(1, 4'd3);
      send(1, 4'd5);
      send(1, 4'd7);
      send(1, 4'd3);
      check("retrig_tones", tones(), 16'h0753);
      send(1, 4'd9);
      check("retrig_on9", tones(), 16'h9753);
      send(1, 4'd11);
      check("retrig_steal", tones(), 16'h97b3);
      check("retrig_stolen", stolen, 1);
      send(1, 4'd9);
      check("dup_tones", tones(), 16'h97b3);
      check("dup_stolen", stolen, 0);
      // all_off lands on the UPDATE edge of note-on 6
      wait_ready();
      vif.note_valid = 1'b1;
      vif.note_on = 1'b1;
      vif.note_code = 4'd6;
      @(negedge clk);
      vif.note_valid = 1'b0;
      all_off = 1'b1;
      @(negedge clk);
      all_off = 1'b0;
      check("alloff_upd_tones", tones(), 16'h0000);
      check("alloff_upd_stolen", stolen, 0);
      @(negedge clk);
      check("alloff_upd_later", tones(), 16'h0000);
      send(1, 4'd3);
      send(1, 4'd5);
      wait_ready();
      vif.note_valid = 1'b1;
      vif.note_code = 4'd6;
      @(negedge clk);
      vif.note_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_upd_tones", tones(), 16'h0000);
      check("rst_upd_ready", vif.note_ready, 0);
      check("rst_upd_busy", busy, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_upd_ready_back", vif.note_ready, 1);
      check("rst_upd_no_late", tones(), 16'h0000);
      send(1, 4'd8);
      check("post_rst_on8", tones(), 16'h0008);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
